// File: rtl/branch_resolve_bht_if.sv
// Execute-stage branch bus: request fields driven by the pipeline and the
// registered resolution returned by branch_resolve_bht.
interface branch_resolve_bht_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            flush;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [2:0]      branch_control;
    logic            pred_taken_in;

    logic            out_valid;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic            out_mispredict;
    logic [XLEN-1:0] out_redirect_pc;

    modport master (
        output in_valid, flush, pc, imm, rs1_val, rs2_val, branch_control, pred_taken_in,
        input  out_valid, out_taken, out_target, out_mispredict, out_redirect_pc
    );

    modport slave (
        input  in_valid, flush, pc, imm, rs1_val, rs2_val, branch_control, pred_taken_in,
        output out_valid, out_taken, out_target, out_mispredict, out_redirect_pc
    );
endinterface

// File: rtl/branch_resolve_bht.sv
// Registered branch resolution with a bimodal 2-bit BHT, misprediction redirect
// and saturating branch / mispredict performance counters.
module branch_resolve_bht #(
    parameter int         XLEN        = 32,
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] CTR_INIT    = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [XLEN-1:0]    pred_pc,
    output logic               pred_taken,
    branch_resolve_bht_if.slave br,
    output logic [CNT_W-1:0]   branch_count,
    output logic [CNT_W-1:0]   mispredict_count
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]      r_bht [BHT_ENTRIES];
    logic            r_out_valid;
    logic            r_out_taken;
    logic [XLEN-1:0] r_out_target;
    logic            r_out_mispredict;
    logic [XLEN-1:0] r_out_redirect_pc;
    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_legal;
    logic             w_taken;
    logic             w_accept;
    logic [XLEN-1:0]  w_target;
    logic [XLEN-1:0]  w_seq_pc;
    logic [1:0]       w_ctr_cur;
    logic [1:0]       w_ctr_nxt;

    assign w_pred_idx = pred_pc[IDX_W+1:2];
    assign w_upd_idx  = br.pc[IDX_W+1:2];
    assign pred_taken = r_bht[w_pred_idx][1];

    always_comb begin
        w_legal = 1'b1;
        w_taken = 1'b0;
        case (br.branch_control)
            3'b000:  w_taken = (br.rs1_val == br.rs2_val);
            3'b001:  w_taken = (br.rs1_val != br.rs2_val);
            3'b100:  w_taken = ($signed(br.rs1_val) <  $signed(br.rs2_val));
            3'b101:  w_taken = ($signed(br.rs1_val) >= $signed(br.rs2_val));
            3'b110:  w_taken = (br.rs1_val <  br.rs2_val);
            3'b111:  w_taken = (br.rs1_val >= br.rs2_val);
            default: w_legal = 1'b0;
        endcase
    end

    assign w_accept = br.in_valid & ~br.flush & w_legal;
    assign w_target = br.pc + br.imm;
    assign w_seq_pc = br.pc + XLEN'(4);

    always_comb begin
        w_ctr_cur = r_bht[w_upd_idx];
        w_ctr_nxt = w_ctr_cur;
        if (w_taken) begin
            if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'b01;
        end else begin
            if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_INIT;
            r_out_valid        <= 1'b0;
            r_out_taken        <= 1'b0;
            r_out_target       <= '0;
            r_out_mispredict   <= 1'b0;
            r_out_redirect_pc  <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_out_valid <= w_accept;
            // Data outputs only move on accept so they hold their last value otherwise.
            if (w_accept) begin
                r_bht[w_upd_idx]  <= w_ctr_nxt;
                r_out_taken       <= w_taken;
                r_out_target      <= w_target;
                r_out_mispredict  <= w_taken ^ br.pred_taken_in;
                r_out_redirect_pc <= w_taken ? w_target : w_seq_pc;
                if (r_branch_count != '1)
                    r_branch_count <= r_branch_count + CNT_W'(1);
                if ((w_taken ^ br.pred_taken_in) && (r_mispredict_count != '1))
                    r_mispredict_count <= r_mispredict_count + CNT_W'(1);
            end
        end
    end

    assign br.out_valid       = r_out_valid;
    assign br.out_taken       = r_out_taken;
    assign br.out_target      = r_out_target;
    assign br.out_mispredict  = r_out_mispredict;
    assign br.out_redirect_pc = r_out_redirect_pc;
    assign branch_count       = r_branch_count;
    assign mispredict_count   = r_mispredict_count;
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed and randomized bench for branch_resolve_bht against a behavioural model.
module tb_branch_resolve_bht;
    localparam int XLEN  = 32;
    localparam int NENT  = 64;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic [XLEN-1:0]  pred_pc;
    logic             pred_taken;
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] mcnt;

    branch_resolve_bht_if #(.XLEN(XLEN)) bus ();

    branch_resolve_bht #(
        .XLEN(XLEN), .BHT_ENTRIES(NENT), .CTR_INIT(2'b01), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken),
        .br(bus), .branch_count(bcnt), .mispredict_count(mcnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    int        m_bht [NENT];
    bit        m_valid, m_taken, m_misp;
    bit [31:0] m_target, m_redir;
    int        m_bc, m_mc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit cond(input bit [2:0] f, input bit [31:0] a, input bit [31:0] b);
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return $signed(a) < $signed(b);
            3'd5: return $signed(a) >= $signed(b);
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int idx(input bit [31:0] a);
        return int'((a >> 2) % NENT);
    endfunction

    // Reference model: state advances at each rising edge from the stable inputs.
    always @(posedge clk) begin
        bit acc, t;
        int i;
        if (rst) begin
            for (int k = 0; k < NENT; k++) m_bht[k] = 1;
            m_valid = 0; m_taken = 0; m_misp = 0; m_target = 0; m_redir = 0;
            m_bc = 0; m_mc = 0;
        end else begin
            acc = bus.in_valid && !bus.flush &&
                  !(bus.branch_control == 3'd2 || bus.branch_control == 3'd3);
            m_valid = acc;
            if (acc) begin
                t = cond(bus.branch_control, bus.rs1_val, bus.rs2_val);
                m_taken  = t;
                m_target = bus.pc + bus.imm;
                m_redir  = t ? bus.pc + bus.imm : bus.pc + 4;
                m_misp   = (t != bus.pred_taken_in);
                i = idx(bus.pc);
                m_bht[i] = t ? ((m_bht[i] + 1 > 3) ? 3 : m_bht[i] + 1)
                             : ((m_bht[i] - 1 < 0) ? 0 : m_bht[i] - 1);
                if (m_bc < CMAX) m_bc++;
                if (m_misp && m_mc < CMAX) m_mc++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid",       bus.out_valid,       m_valid);
            chk("out_taken",       bus.out_taken,       m_taken);
            chk("out_target",      bus.out_target,      m_target);
            chk("out_mispredict",  bus.out_mispredict,  m_misp);
            chk("out_redirect_pc", bus.out_redirect_pc, m_redir);
            chk("branch_count",    bcnt,                m_bc);
            chk("mispredict_count", mcnt,               m_mc);
            chk("pred_taken",      pred_taken,          m_bht[idx(pred_pc)] >= 2);
        end
    end

    task automatic cyc(input bit r, input bit v, input bit f, input bit [31:0] p,
                       input bit [31:0] im, input bit [31:0] a, input bit [31:0] b,
                       input bit [2:0] bc, input bit pti, input bit [31:0] ppc);
        #1;
        rst = r; bus.in_valid = v; bus.flush = f; bus.pc = p; bus.imm = im;
        bus.rs1_val = a; bus.rs2_val = b; bus.branch_control = bc;
        bus.pred_taken_in = pti; pred_pc = ppc;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic bit [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit [31:0] p, a, b;
        rst = 1; bus.in_valid = 0; bus.flush = 0; bus.pc = 0; bus.imm = 0;
        bus.rs1_val = 0; bus.rs2_val = 0; bus.branch_control = 0;
        bus.pred_taken_in = 0; pred_pc = 0;

        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst branch_count", bcnt, 0);
        chk("rst pred_taken", pred_taken, 0);

        cyc(0, 1, 0, 32'h100, 32'h20, 5, 5, 3'd0, 0, 32'h100);
        chk("beq out_valid", bus.out_valid, 1);
        chk("beq out_target", bus.out_target, 32'h120);
        chk("beq redirect", bus.out_redirect_pc, 32'h120);
        chk("beq mispredict", bus.out_mispredict, 1);
        chk("beq counts", {bcnt, mcnt}, {4'd1, 4'd1});

        cyc(0, 1, 0, 32'h200, 32'h10, 32'hFFFF_FFFF, 1, 3'd4, 1, 0);
        chk("blt taken", bus.out_taken, 1);
        cyc(0, 1, 0, 32'h200, 32'h10, 32'hFFFF_FFFF, 1, 3'd6, 0, 0);
        chk("bltu taken", bus.out_taken, 0);
        chk("bltu redirect", bus.out_redirect_pc, 32'h204);

        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 32'h40, 4, 5, 5, 3'd0, 0, 32'h40);
            chk("train pred up", pred_taken, 1);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h140);
        chk("alias 0x140", pred_taken, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44);
        chk("neighbour 0x44", pred_taken, 0);
        cyc(0, 1, 0, 32'h40, 4, 5, 5, 3'd1, 0, 32'h40);
        chk("untrain 1", pred_taken, 1);
        cyc(0, 1, 0, 32'h40, 4, 5, 5, 3'd1, 0, 32'h40);
        chk("untrain 2", pred_taken, 0);
        cyc(0, 1, 0, 32'h40, 4, 5, 5, 3'd1, 0, 32'h40);
        chk("untrain 3", pred_taken, 0);
        chk("counts before flush", {bcnt, mcnt}, {4'd10, 4'd5});

        cyc(0, 1, 1, 32'h44, 4, 5, 5, 3'd0, 0, 32'h44);
        chk("flush out_valid", bus.out_valid, 0);
        chk("flush counts", {bcnt, mcnt}, {4'd10, 4'd5});
        cyc(0, 1, 0, 32'h44, 4, 5, 5, 3'd2, 0, 32'h44);
        chk("illegal out_valid", bus.out_valid, 0);
        chk("illegal pred", pred_taken, 0);
        chk("illegal counts", {bcnt, mcnt}, {4'd10, 4'd5});

        cyc(0, 1, 0, 32'h80, 4, 5, 5, 3'd0, 0, 32'h80);
        chk("pre-rst valid", bus.out_valid, 1);
        cyc(1, 1, 0, 32'h80, 4, 5, 5, 3'd0, 0, 32'h80);
        chk("rst valid", bus.out_valid, 0);
        chk("rst target", bus.out_target, 0);
        chk("rst redirect", bus.out_redirect_pc, 0);
        chk("rst counts", {bcnt, mcnt}, 0);
        chk("rst pred 0x80", pred_taken, 0);

        cyc(0, 1, 0, 32'hFFFF_FFFC, 8, 5, 5, 3'd0, 0, 0);
        chk("wrap target", bus.out_target, 32'h4);
        cyc(0, 1, 0, 32'hFFFF_FFFC, 8, 5, 5, 3'd1, 0, 0);
        chk("wrap redirect", bus.out_redirect_pc, 32'h0);
        for (int k = 0; k < 20; k++) cyc(0, 1, 0, 32'h300, 4, 1, 1, 3'd0, 0, 0);
        chk("sat branch_count", bcnt, 15);
        chk("sat mispredict_count", mcnt, 15);

        for (int k = 0; k < 3000; k++) begin
            p = (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 3)) << 8);
            a = pick_val();
            b = ($urandom_range(0, 9) < 3) ? a : pick_val();
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 8),
                ($urandom_range(0, 9) == 0), p, $urandom, a, b,
                3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? p
                    : (32'($urandom_range(0, 7)) << 2) + (32'($urandom_range(0, 3)) << 8));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
- Parametrised, registered branch-resolution unit for the RISC-V core. Successor to the single-cycle combinational branch comparator.
- Resolves conditional branches in the execute stage with a one-cycle registered result.
- Holds a bimodal branch history table (BHT) of 2-bit saturating counters. Fetch reads it for prediction; resolution updates it.
- Flags mispredictions, produces the redirect PC for fetch, and keeps saturating performance counters.

Parameters:
- XLEN, 32, data/address width in bits.
- BHT_ENTRIES, 64, number of BHT counters; power of two, >= 2.
- CTR_INIT, 2'b01, counter reset value (weakly not-taken).
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- pred_pc  in  XLEN  fetch PC to look up in the BHT.
- pred_taken  out  1  combinational prediction = BHT[idx(pred_pc)][1].
- in_valid  in  1  execute stage presents a branch this cycle.
- flush  in  1  kill the current input (younger-instruction squash).
- pc  in  XLEN  PC of the branch.
- imm  in  XLEN  sign-extended B-immediate.
- rs1_val  in  XLEN  operand 1.
- rs2_val  in  XLEN  operand 2.
- branch_control  in  3  funct3 encoding of the branch.
- pred_taken_in  in  1  prediction fetch used for this branch (piped down).
- out_valid  out  1  registered: a resolved branch is presented.
- out_taken  out  1  registered: the branch condition was true.
- out_target  out  XLEN  registered: pc+imm.
- out_mispredict  out  1  registered: out_taken != pred_taken_in.
- out_redirect_pc  out  XLEN  registered: out_taken ? pc+imm : pc+4.
- branch_count  out  CNT_W  resolved branches, saturating.
- mispredict_count  out  CNT_W  mispredictions, saturating.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Index: idx(a) = a[log2(BHT_ENTRIES)+1 : 2]. PC bits [1:0] are ignored.
- Encodings: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - BLT/BGE use signed compare; BLTU/BGEU use unsigned.
  - 010 and 011 are illegal: not a branch.
- Accept: accept = in_valid & ~flush & legal(branch_control). The accepting cycle is N.
- Latency: exactly 1 cycle. Outputs reflect cycle-N inputs in cycle N+1.
  - out_valid is 0 in any cycle that follows a non-accept cycle.
  - Data outputs are don't-care when out_valid=0, but hold their previous values (no X).
- Arithmetic: pc+imm and pc+4 are XLEN-bit modulo; wrap-around is silently discarded.
- BHT update at the end of cycle N, on accept only:
  - taken: ctr = min(ctr+1, 3).
  - not taken: ctr = max(ctr-1, 0).
  - Counters saturate at 3 and 0.
- Read/write collision: pred_taken is a combinational read of current state. If pred_pc and pc map to the same index in cycle N, pred_taken shows the pre-update value in N and the updated value from N+1.
- Performance counters, updated at the end of N on accept:
  - branch_count += 1.
  - mispredict_count += 1 if the computed taken != pred_taken_in.
  - Both hold at 2^CNT_W-1.
- Flush: with in_valid=1, flush=1 → no output, no BHT update, no counter change.
  - Flush does not retract an out_valid already presented in the current cycle.
- Illegal code with in_valid=1 → treated as not accepted (same effect as flush).
- Reset (synchronous):
  - out_valid=0, out_taken=0, out_mispredict=0, out_target=0, out_redirect_pc=0.
  - All BHT counters = CTR_INIT; both performance counters = 0.
  - A branch accepted in the same cycle as rst is discarded.
  - Reset mid-stream fully clears history.
- No backpressure: the consumer must take out_* in the cycle out_valid=1.

Test Plan:
- Reset then BEQ, pc=0x100, imm=0x20, rs1=rs2=5, pred_taken_in=0 → next cycle: out_valid=1, out_taken=1, out_target=0x120, out_redirect_pc=0x120, out_mispredict=1, branch_count=1, mispredict_count=1.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU with the same operands → not taken, out_redirect_pc=pc+4. Sweep all six codes with equal, less and greater operands.
- Four taken branches at pc=0x40 with pred_pc=0x40 → pred_taken 0→1 after the first update (CTR_INIT=01→10); counter saturates at 3. Then three not-taken → pred_taken returns to 0 at ctr=1.
- Aliasing: pc=0x40 and pc=0x140 with BHT_ENTRIES=64 share index 16 → an update at one is visible at the other. pc=0x44 is unaffected.
- in_valid=1 with flush=1, and separately branch_control=010 → out_valid=0 next cycle, BHT and counters unchanged. rst asserted while out_valid=1 → all outputs and counters 0 next cycle, pred_taken=CTR_INIT[1].
- Wrap: pc=0xFFFFFFFC, imm=8, taken → out_target=0x4. Not taken → out_redirect_pc=0x0. Counter saturation with CNT_W=4: 20 branches → branch_count=15.
